ff_bank: RTL and testbench

//  - WIDTH-channel register bank; each bit is a clocked flip-flop whose type is set by mode: SR, JK, D or T.
//  - Successor to the single-bit SR flip-flop; defined SR=11 policy replaces the X output.
//  - Adds sticky per-bit illegal-input flags, a saturating change counter and an optional edge-pulse output.
//  - Used as a general state/flag register inside control blocks.

---
 rtl/ff_bank.sv | 72 +++++++
 tb/tb_ff_bank.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ff_bank.sv
// ff_bank: WIDTH-channel SR/JK/D/T flip-flop bank with sticky illegal flags and saturating change counter.
// Define FF_BANK_EDGE_EN to add registered q_rise/q_fall edge pulses.
module ff_bank #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int SR11_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             illegal_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] chg_cnt
`ifdef FF_BANK_EDGE_EN
    ,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall
`endif
);
    logic [WIDTH-1:0] q_q, q_d, illegal_q, illegal_d;
    logic [WIDTH-1:0] sr11, sr_nxt, jk_nxt, nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef FF_BANK_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
`endif
    always_comb begin
        sr11 = SR11_POLICY == 1 ? '0 : SR11_POLICY == 2 ? '1 : SR11_POLICY == 3 ? ~q_q : q_q;
        sr_nxt = (a & ~b) | (~a & ~b & q_q) | (a & b & sr11);
        jk_nxt = (a & ~q_q) | (~b & q_q);
        nxt = mode == 2'b00 ? sr_nxt : mode == 2'b01 ? jk_nxt : mode == 2'b10 ? a : q_q ^ a;
        q_d = en ? nxt : q_q;
        // a same-edge illegal event beats the clear for that bit
        illegal_d = (illegal_clr ? '0 : illegal_q) | ((en && mode == 2'b00) ? (a & b) : '0);
        cnt_d = (q_d != q_q && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef FF_BANK_EDGE_EN
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q       <= '0;
            illegal_q <= '0;
            cnt_q     <= '0;
`ifdef FF_BANK_EDGE_EN
            rise_q    <= '0;
            fall_q    <= '0;
`endif
        end else begin
            q_q       <= q_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
`ifdef FF_BANK_EDGE_EN
            rise_q    <= rise_d;
            fall_q    <= fall_d;
`endif
        end
    end
    assign q       = q_q;
    assign qn      = ~q_q;
    assign illegal = illegal_q;
    assign chg_cnt = cnt_q;
`ifdef FF_BANK_EDGE_EN
    assign q_rise  = rise_q;
    assign q_fall  = fall_q;
`endif
endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed checks of ff_bank (CNT_W=8 and CNT_W=2 instances on shared stimulus).
// Edge-pulse checks are included when FF_BANK_EDGE_EN is defined.
module tb_ff_bank;
    logic       clk = 1'b0;
    logic       rst, en, illegal_clr;
    logic [1:0] mode;
    logic [7:0] a, b;
    logic [7:0] q, qn, illegal, q1, qn1, illegal1;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt1;
    int         n_chk = 0;
    int         n_pass = 0;
`ifdef FF_BANK_EDGE_EN
    logic [7:0] q_rise, q_fall, q_rise1, q_fall1;
`endif

    ff_bank u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .illegal_clr(illegal_clr), .q(q), .qn(qn), .illegal(illegal), .chg_cnt(chg_cnt)
`ifdef FF_BANK_EDGE_EN
        , .q_rise(q_rise), .q_fall(q_fall)
`endif
    );

    ff_bank #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .illegal_clr(illegal_clr), .q(q1), .qn(qn1), .illegal(illegal1), .chg_cnt(chg_cnt1)
`ifdef FF_BANK_EDGE_EN
        , .q_rise(q_rise1), .q_fall(q_fall1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; mode = 2'b10; a = 8'hFF; b = 8'h00; illegal_clr = 1'b0;
        tick();
        chk("rst_q", q, 8'h00);
        chk("rst_qn", qn, 8'hFF);
        chk("rst_ill", illegal, 8'h00);
        chk("rst_cnt", chg_cnt, 0);
        rst = 1'b1;
        mode = 2'b00; a = 8'h0F; b = 8'h00; tick();
        chk("sr_set", q, 8'h0F);
        a = 8'h00; b = 8'h03; tick();
        chk("sr_reset", q, 8'h0C);
        chk("sr_cnt", chg_cnt, 2);
        a = 8'h01; b = 8'h01; tick();
        chk("sr11_hold", q, 8'h0C);
        chk("sr11_ill", illegal, 8'h01);
        chk("sr11_cnt", chg_cnt, 2);
        a = 8'h02; b = 8'h02; illegal_clr = 1'b1; tick();
        chk("clr_vs_set", illegal, 8'h02);
        chk("clr_q", q, 8'h0C);
        a = 8'h00; b = 8'h00; tick();
        chk("clr_only", illegal, 8'h00);
        illegal_clr = 1'b0;
        a = 8'h00; b = 8'hFF; tick();
        chk("sr_clear_all", q, 8'h00);
        mode = 2'b01; a = 8'hFF; b = 8'hFF; tick();
        chk("jk_tog1", q, 8'hFF);
        tick();
        chk("jk_tog2", q, 8'h00);
        tick();
        chk("jk_tog3", q, 8'hFF);
        chk("jk_no_ill", illegal, 8'h00);
        mode = 2'b11; a = 8'h01; tick();
        chk("t_tog", q, 8'hFE);
        chk("t_qn", qn, 8'h01);
        chk("t_cnt", chg_cnt, 7);
        mode = 2'b10; a = 8'h55; en = 1'b0; tick();
        chk("en0_q", q, 8'hFE);
        chk("en0_cnt", chg_cnt, 7);
        mode = 2'b00; a = 8'hFF; b = 8'hFF; tick();
        chk("en0_no_ill", illegal, 8'h00);
        en = 1'b1; mode = 2'b11; a = 8'hFF; rst = 1'b0; tick();
        chk("mid_rst_q", q, 8'h00);
        chk("mid_rst_cnt", chg_cnt, 0);
        rst = 1'b1; mode = 2'b10;
        for (int i = 0; i < 5; i++) begin
            a = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        chk("sat_cnt", chg_cnt1, 3);
        chk("sat_wide_cnt", chg_cnt, 5);
        chk("sat_q", q1, 8'hFF);
        en = 1'b0; a = 8'h00; tick();
        chk("sat_en0_q", q1, 8'hFF);
        chk("sat_en0_cnt", chg_cnt1, 3);
        en = 1'b1; a = 8'h00; tick();
        chk("d_00", q, 8'h00);
        a = 8'h81; tick();
        chk("d_81", q, 8'h81);
`ifdef FF_BANK_EDGE_EN
        chk("rise_81", q_rise, 8'h81);
        chk("fall_0", q_fall, 8'h00);
`endif
        a = 8'h01; tick();
        chk("d_01", q, 8'h01);
`ifdef FF_BANK_EDGE_EN
        chk("rise_0", q_rise, 8'h00);
        chk("fall_80", q_fall, 8'h80);
`endif
        tick();
`ifdef FF_BANK_EDGE_EN
        chk("pulse_end_r", q_rise, 8'h00);
        chk("pulse_end_f", q_fall, 8'h00);
`endif
        chk("d_hold", q, 8'h01);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
